// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing front end:
// FSM states, ALU op codes, instruction layout and status flag positions.
package alu_ctrl_pkg;

    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;
    localparam int DATA_W   = 8;
    localparam int INSTR_W  = 16;
    localparam int CTRL_W   = 4;
    localparam int FLAG_W   = 3;

    // Instruction field bit positions (LSB of each field)
    localparam int MODE_BIT = 15;
    localparam int OP_LSB   = 12;
    localparam int RD_LSB   = 10;
    localparam int RA_LSB   = 8;
    localparam int RB_LSB   = 6;
    localparam int IMM_LSB  = 0;

    localparam logic MODE_ALU = 1'b0;
    localparam logic MODE_LDI = 1'b1;

    // Status flag bit indices within {Z,N,C}
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_NOT = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_t;

    // Instruction word view; 'low' is rb in [7:6] for ALU mode, the immediate for LDI
    typedef struct packed {
        logic              mode;
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] ra;
        logic [DATA_W-1:0] low;
    } instr_t;

endpackage

// File: rtl/alu_control_unit_if.sv
// Instruction handshake plus the ALU control/operand/result bus.
// Signal names are from the control unit's point of view.
interface alu_control_unit_if;
    import alu_ctrl_pkg::*;

    logic                i_Instr_Valid;
    logic [INSTR_W-1:0]  i_Instr;
    logic                o_Instr_Ready;
    logic [CTRL_W-1:0]   o_Control_ALU;
    logic [INSTR_W-1:0]  o_Operandos;
    logic [DATA_W-1:0]   i_Resultado;
    logic [FLAG_W-1:0]   i_Banderas_Estado;

    // Control unit side: takes instructions, initiates ALU operations
    modport master (
        input  i_Instr_Valid, i_Instr, i_Resultado, i_Banderas_Estado,
        output o_Instr_Ready, o_Control_ALU, o_Operandos
    );

    // Instruction source and ALU side
    modport slave (
        output i_Instr_Valid, i_Instr, i_Resultado, i_Banderas_Estado,
        input  o_Instr_Ready, o_Control_ALU, o_Operandos
    );
endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: one synchronous write port, three combinational
// read ports (two source operands and a debug port), asynchronous clear.
module alu_regfile
    import alu_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [REG_AW-1:0] rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Write port; reset clears every register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = mem_q[ra_addr_i];
    assign rb_data_o  = mem_q[rb_addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_control_unit.sv
// Sequencer between the instruction source and the ALU. Accepts one
// instruction at a time, reads sources, runs the ALU for one cycle,
// captures result/flags and writes back into the register file.
module alu_control_unit
    import alu_ctrl_pkg::*;
(
    input  logic                i_Clk,
    input  logic                i_Reset_n,
    alu_control_unit_if.master  bus,
    output logic                o_Done,
    output logic [DATA_W-1:0]   o_Result,
    output logic [FLAG_W-1:0]   o_Flags,
    input  logic [REG_AW-1:0]   i_Read_Addr,
    output logic [DATA_W-1:0]   o_Read_Data
);

    state_t              state_q, state_d;
    instr_t              instr_in;
    logic                accept;
    logic                wb_en;
    logic [DATA_W-1:0]   wb_data;
    logic [DATA_W-1:0]   ra_data, rb_data;

    // Latched instruction fields (sources are consumed at accept time)
    logic                mode_q;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [DATA_W-1:0]   imm_q;

    logic [INSTR_W-1:0]  operands_q;
    logic [DATA_W-1:0]   alu_res_q, result_q;
    logic [FLAG_W-1:0]   alu_flags_q, flags_q;

    assign instr_in = instr_t'(bus.i_Instr);
    assign accept   = bus.i_Instr_Valid && (state_q == ST_IDLE);
    assign wb_data  = (mode_q == MODE_LDI) ? imm_q : alu_res_q;

    // Sources are read straight from the incoming word while idle; the
    // previous write-back has already landed by then, so rd==ra/rb chains work.
    alu_regfile u_regfile (
        .clk_i      (i_Clk),
        .rst_ni     (i_Reset_n),
        .we_i       (wb_en),
        .waddr_i    (rd_q),
        .wdata_i    (wb_data),
        .ra_addr_i  (instr_in.ra),
        .ra_data_o  (ra_data),
        .rb_addr_i  (instr_in.low[7:6]),
        .rb_data_o  (rb_data),
        .dbg_addr_i (i_Read_Addr),
        .dbg_data_o (o_Read_Data)
    );

    // FSM state register
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; LDI skips the ALU cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept) state_d = ST_DECODE;
            ST_DECODE:    state_d = (mode_q == MODE_LDI) ? ST_WRITEBACK : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only when idle, ALU enable only in EXECUTE
    always_comb begin
        bus.o_Instr_Ready = 1'b0;
        bus.o_Control_ALU = '0;
        o_Done            = 1'b0;
        wb_en             = 1'b0;
        case (state_q)
            ST_IDLE:      bus.o_Instr_Ready = 1'b1;
            ST_DECODE:    bus.o_Control_ALU = {1'b0, op_q};
            ST_EXECUTE:   bus.o_Control_ALU = {1'b1, op_q};
            ST_WRITEBACK: begin
                o_Done = 1'b1;
                wb_en  = 1'b1;
            end
            default: ;
        endcase
    end

    // Instruction latch, operand register, ALU capture and status registers
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            mode_q      <= MODE_ALU;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            operands_q  <= '0;
            alu_res_q   <= '0;
            alu_flags_q <= '0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            if (accept) begin
                mode_q     <= instr_in.mode;
                op_q       <= instr_in.op;
                rd_q       <= instr_in.rd;
                imm_q      <= instr_in.low;
                operands_q <= {rb_data, ra_data};
            end
            if (state_q == ST_EXECUTE) begin
                alu_res_q   <= bus.i_Resultado;
                alu_flags_q <= bus.i_Banderas_Estado;
            end
            if (wb_en) begin
                result_q <= wb_data;
                if (mode_q == MODE_ALU) begin
                    flags_q <= alu_flags_q;
                end
            end
        end
    end

    assign bus.o_Operandos = operands_q;
    assign o_Result        = result_q;
    assign o_Flags         = flags_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: behavioural ALU attached to the bus,
// register-file model feeding a scoreboard of expected write-backs.
module tb_alu_control_unit;
    import alu_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] rd;
        logic [7:0] res;
        logic [2:0] flg;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done;
    logic [7:0] result;
    logic [2:0] flags;
    logic [1:0] read_addr;
    logic [7:0] read_data;

    alu_control_unit_if bus();

    alu_control_unit dut (
        .i_Clk       (clk),
        .i_Reset_n   (rst_n),
        .bus         (bus),
        .o_Done      (done),
        .o_Result    (result),
        .o_Flags     (flags),
        .i_Read_Addr (read_addr),
        .o_Read_Data (read_data)
    );

    always #5 clk = ~clk;

    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    int        hs_cnt  = 0;
    int        done_cnt = 0;
    int        sent_cnt = 0;
    int        last_acc = 0;
    int        last_len = 0;
    bit        hold_valid = 1'b0;
    bit        chk_interval = 1'b0;
    sb_entry_t sb_q[$];
    logic [7:0] regs_m [4];
    logic [2:0] flags_m;

    // Reference ALU: C = signed overflow, N = true sign of the result
    function automatic logic [10:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [7:0] r;
        logic       v;
        logic [2:0] f;
        r = 8'h00;
        v = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
            OP_SUB: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
            OP_SHL: r = (b > 8'd7) ? 8'h00 : (a << b);
            OP_SHR: r = (b > 8'd7) ? 8'h00 : (a >> b);
            OP_NOT: r = ~b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = 8'h00;
        endcase
        f = 3'b000;
        f[FLAG_Z] = (r == 8'h00);
        f[FLAG_N] = r[7] ^ v;
        f[FLAG_C] = v;
        return {f, r};
    endfunction

    // ALU attached to the bus: combinational while enabled, holds otherwise
    logic [10:0] alu_now, alu_hold;
    assign alu_now = alu_model(bus.o_Control_ALU[2:0], bus.o_Operandos[7:0], bus.o_Operandos[15:8]);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_hold <= '0;
        else if (bus.o_Control_ALU[3]) alu_hold <= alu_now;
    end
    assign bus.i_Resultado       = bus.o_Control_ALU[3] ? alu_now[7:0]  : alu_hold[7:0];
    assign bus.i_Banderas_Estado = bus.o_Control_ALU[3] ? alu_now[10:8] : alu_hold[10:8];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.i_Instr_Valid && bus.o_Instr_Ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [15:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                           input logic [1:0] ra, input logic [1:0] rb);
        logic [15:0] w;
        w = 16'h0000;
        w[MODE_BIT]    = MODE_ALU;
        w[OP_LSB +: 3] = op;
        w[RD_LSB +: 2] = rd;
        w[RA_LSB +: 2] = ra;
        w[RB_LSB +: 2] = rb;
        return w;
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
        logic [15:0] w;
        w = 16'h0000;
        w[MODE_BIT]     = MODE_LDI;
        w[RD_LSB +: 2]  = rd;
        w[IMM_LSB +: 8] = imm;
        return w;
    endfunction

    // Predict the write-back, push it, then present the instruction until accepted
    task automatic send(input logic [15:0] ins, input bit dir, input logic [7:0] xr,
                        input logic [2:0] xf);
        sb_entry_t   e;
        logic [10:0] p;
        bit          ok;
        int          hs0;
        e.rd = ins[11:10];
        if (ins[15]) begin
            e.res = ins[7:0];
            e.flg = flags_m;
        end else begin
            p = alu_model(ins[14:12], regs_m[ins[9:8]], regs_m[ins[7:6]]);
            e.res = p[7:0];
            e.flg = p[10:8];
        end
        if (dir) begin
            e.res = xr;
            e.flg = xf;
        end
        regs_m[e.rd] = e.res;
        flags_m = e.flg;
        sb_q.push_back(e);
        sent_cnt++;
        bus.i_Instr_Valid = 1'b1;
        bus.i_Instr = ins;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.o_Instr_Ready === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        check_val("accept_in_time", 32'(ok), 32'(1));
        if (ok) begin
            hs0 = hs_cnt;
            @(posedge clk);
            #1;
            check_val("accept_once", 32'(hs_cnt - hs0), 32'(1));
            if (chk_interval && last_len != 0)
                check_val("accept_interval", 32'(cyc - last_acc), 32'(last_len));
            last_acc = cyc;
            last_len = ins[15] ? 3 : 4;
        end
        if (!hold_valid) bus.i_Instr_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.o_Instr_Ready !== 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_in_time", 32'(n < 60), 32'(1));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: each o_Done pops one expectation; results checked after the write edge
    initial begin : monitor
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                done_cnt++;
                check_val("done_expected", 32'(sb_q.size() != 0), 32'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    read_addr = e.rd;
                    @(negedge clk);
                    check_val("result", 32'(result), 32'(e.res));
                    check_val("flags", 32'(flags), 32'(e.flg));
                    check_val("regfile_rd", 32'(read_data), 32'(e.res));
                    check_val("done_pulse", 32'(done), 32'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int snap;
        logic [15:0] ins;
        for (int i = 0; i < 4; i++) regs_m[i] = 8'h00;
        flags_m = 3'b000;
        rst_n = 1'b0;
        bus.i_Instr_Valid = 1'b0;
        bus.i_Instr = 16'h0000;
        read_addr = 2'd0;
        repeat (3) @(negedge clk);
        check_val("rst_ctrl", 32'(bus.o_Control_ALU), 32'(0));
        check_val("rst_operands", 32'(bus.o_Operandos), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        check_val("rst_result", 32'(result), 32'(0));
        check_val("rst_flags", 32'(flags), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", 32'(bus.o_Instr_Ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            read_addr = 2'(i);
            #1;
            check_val("rst_regfile", 32'(read_data), 32'(0));
        end
        @(negedge clk);

        // Load immediates and add
        send(mk_ldi(2'd0, 8'h05), 1'b0, 8'h00, 3'b000); wait_idle();
        send(mk_ldi(2'd1, 8'h03), 1'b0, 8'h00, 3'b000); wait_idle();
        send(mk_alu(OP_ADD, 2'd2, 2'd0, 2'd1), 1'b1, 8'h08, 3'b000); wait_idle();

        // SUB with negative result, with control/operand trace
        send(mk_alu(OP_SUB, 2'd3, 2'd1, 2'd0), 1'b1, 8'hFE, 3'b010);
        @(negedge clk);
        check_val("sub_decode_ctrl", 32'(bus.o_Control_ALU), 32'(4'b0001));
        check_val("sub_decode_ops", 32'(bus.o_Operandos), 32'(16'h0503));
        @(negedge clk);
        check_val("sub_exec_ctrl", 32'(bus.o_Control_ALU), 32'(4'b1001));
        check_val("sub_exec_ops", 32'(bus.o_Operandos), 32'(16'h0503));
        @(negedge clk);
        check_val("sub_wb_ctrl", 32'(bus.o_Control_ALU), 32'(4'b0000));
        wait_idle();

        // Signed overflow add
        send(mk_ldi(2'd0, 8'h7F), 1'b0, 8'h00, 3'b000); wait_idle();
        send(mk_ldi(2'd1, 8'h01), 1'b0, 8'h00, 3'b000); wait_idle();
        send(mk_alu(OP_ADD, 2'd2, 2'd0, 2'd1), 1'b1, 8'h80, 3'b001); wait_idle();

        // XOR into its own source, then LDI must keep the flags
        send(mk_alu(OP_XOR, 2'd0, 2'd0, 2'd0), 1'b1, 8'h00, 3'b100); wait_idle();
        send(mk_ldi(2'd3, 8'hAA), 1'b1, 8'hAA, 3'b100); wait_idle();

        // Back-to-back with valid held high
        hold_valid = 1'b1;
        chk_interval = 1'b1;
        last_len = 0;
        send(mk_ldi(2'd0, 8'h9C), 1'b0, 8'h00, 3'b000);
        send(mk_ldi(2'd1, 8'h02), 1'b0, 8'h00, 3'b000);
        send(mk_alu(OP_SHL, 2'd2, 2'd0, 2'd1), 1'b0, 8'h00, 3'b000);
        send(mk_alu(OP_SHR, 2'd3, 2'd0, 2'd1), 1'b0, 8'h00, 3'b000);
        send(mk_alu(OP_NOT, 2'd1, 2'd0, 2'd2), 1'b0, 8'h00, 3'b000);
        send(mk_alu(OP_AND, 2'd0, 2'd2, 2'd3), 1'b0, 8'h00, 3'b000);
        send(mk_ldi(2'd2, 8'h81), 1'b0, 8'h00, 3'b000);
        send(mk_alu(OP_OR,  2'd3, 2'd2, 2'd0), 1'b0, 8'h00, 3'b000);
        send(mk_alu(OP_SUB, 2'd0, 2'd1, 2'd3), 1'b0, 8'h00, 3'b000);
        for (int k = 0; k < 6; k++) begin
            ins = 16'($urandom);
            send(ins, 1'b0, 8'h00, 3'b000);
        end
        hold_valid = 1'b0;
        chk_interval = 1'b0;
        bus.i_Instr_Valid = 1'b0;
        wait_idle();

        // Reset during EXECUTE of ADD r2
        send(mk_ldi(2'd0, 8'h11), 1'b0, 8'h00, 3'b000); wait_idle();
        send(mk_ldi(2'd1, 8'h22), 1'b0, 8'h00, 3'b000); wait_idle();
        send(mk_alu(OP_ADD, 2'd2, 2'd0, 2'd1), 1'b0, 8'h00, 3'b000);
        @(negedge clk);
        @(negedge clk);
        check_val("abort_in_exec", 32'(bus.o_Control_ALU), 32'(4'b1000));
        snap = done_cnt;
        rst_n = 1'b0;
        #1;
        check_val("abort_ctrl", 32'(bus.o_Control_ALU), 32'(0));
        check_val("abort_operands", 32'(bus.o_Operandos), 32'(0));
        check_val("abort_done", 32'(done), 32'(0));
        check_val("abort_result", 32'(result), 32'(0));
        check_val("abort_flags", 32'(flags), 32'(0));
        sent_cnt = sent_cnt - sb_q.size();
        sb_q.delete();
        for (int i = 0; i < 4; i++) regs_m[i] = 8'h00;
        flags_m = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("abort_no_done", 32'(done_cnt), 32'(snap));
        read_addr = 2'd2;
        #1;
        check_val("abort_r2", 32'(read_data), 32'(0));
        check_val("abort_ready", 32'(bus.o_Instr_Ready), 32'(1));

        // Unit still works after the abort
        send(mk_ldi(2'd2, 8'h5A), 1'b0, 8'h00, 3'b000); wait_idle();

        check_val("done_count", 32'(done_cnt), 32'(sent_cnt));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
